// File: rtl/mem_bus_arb.sv
// Memory bus arbiter: serialises instruction-fetch and data requests onto a
// single shared memory port. Data requests win ties. A fetch that is flushed
// mid-flight is drained silently, and the block produces the pipeline stall
// vector.
module mem_bus_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic [6:0]  stall
);

  localparam int unsigned ST_W    = 3;
  localparam int unsigned SIZE_W  = 2;
  localparam int unsigned STALL_W = 7;

  localparam logic [ST_W-1:0] S_IDLE   = ST_W'(0);
  localparam logic [ST_W-1:0] S_I_ADDR = ST_W'(1);
  localparam logic [ST_W-1:0] S_I_DATA = ST_W'(2);
  localparam logic [ST_W-1:0] S_D_ADDR = ST_W'(3);
  localparam logic [ST_W-1:0] S_D_DATA = ST_W'(4);

  localparam logic [SIZE_W-1:0]  SIZE_WORD  = SIZE_W'(2);
  localparam logic [STALL_W-1:0] STALL_DATA = STALL_W'(7'b0111111);
  localparam logic [STALL_W-1:0] STALL_INST = STALL_W'(7'b0000011);

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] next_state;
  logic            accept_i;
  logic            accept_d;
  logic            done_i;
  logic            done_d;
  logic            discard;
  logic            ok_pulse;
  logic            fetch_busy;
  logic            data_busy;
  logic            inst_deliver;

  assign ok_pulse     = inst_ok | data_ok;
  assign fetch_busy   = (state == S_I_ADDR) || (state == S_I_DATA);
  assign data_busy    = (state == S_D_ADDR) || (state == S_D_DATA);
  // A fetch flushed at any point before (or in) its completion cycle is dropped.
  assign inst_deliver = done_i && !discard && !flush;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // Next-state logic and transaction strobes; no acceptance while an ok pulse is out.
  always_comb begin
    next_state = state;
    accept_i   = 1'b0;
    accept_d   = 1'b0;
    done_i     = 1'b0;
    done_d     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!ok_pulse && !flush) begin
          if (data_req) begin
            next_state = S_D_ADDR;
            accept_d   = 1'b1;
          end else if (inst_req) begin
            next_state = S_I_ADDR;
            accept_i   = 1'b1;
          end
        end
      end
      S_I_ADDR: begin
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            next_state = S_IDLE;
            done_i     = 1'b1;
          end else begin
            next_state = S_I_DATA;
          end
        end
      end
      S_I_DATA: begin
        if (bus_data_ok) begin
          next_state = S_IDLE;
          done_i     = 1'b1;
        end
      end
      S_D_ADDR: begin
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            next_state = S_IDLE;
            done_d     = 1'b1;
          end else begin
            next_state = S_D_DATA;
          end
        end
      end
      S_D_DATA: begin
        if (bus_data_ok) begin
          next_state = S_IDLE;
          done_d     = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Registered bus request fields, completion pulses, read data and discard flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req    <= 1'b0;
      bus_wr     <= 1'b0;
      bus_size   <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      inst_ok    <= 1'b0;
      data_ok    <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
      discard    <= 1'b0;
    end else begin
      bus_req <= (next_state == S_I_ADDR) || (next_state == S_D_ADDR);
      inst_ok <= inst_deliver;
      data_ok <= done_d;
      if (accept_d) begin
        bus_wr    <= data_wr;
        bus_size  <= data_size;
        bus_addr  <= data_addr;
        bus_wdata <= data_wdata;
      end else if (accept_i) begin
        bus_wr    <= 1'b0;
        bus_size  <= SIZE_WORD;
        bus_addr  <= inst_addr;
        bus_wdata <= '0;
      end
      if (inst_deliver) inst_rdata <= bus_rdata;
      if (done_d)       data_rdata <= bus_rdata;
      if (next_state == S_IDLE)   discard <= 1'b0;
      else if (flush && fetch_busy) discard <= 1'b1;
    end
  end

  // Stall vector: data access stops everything up to dc, fetch stops pc/if;
  // released in the ok cycle so the stage advances exactly once.
  always_comb begin
    stall = '0;
    if (!rst || ok_pulse) begin
      stall = '0;
    end else if (data_busy || (state == S_IDLE && data_req && !flush)) begin
      stall = STALL_DATA;
    end else if (fetch_busy || (state == S_IDLE && inst_req && !flush)) begin
      stall = STALL_INST;
    end
  end

endmodule

// File: tb/tb_mem_bus_arb.sv
// Testbench for mem_bus_arb: directed transactions with literal expectations,
// plus a transaction-level model compared against the DUT every cycle.
module tb_mem_bus_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ok;
  logic [31:0] data_rdata;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic [6:0]  stall;

  always #5 clk = ~clk;

  mem_bus_arb dut (
    .clk(clk), .rst(rst), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ok(inst_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ok(data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .stall(stall)
  );

  int n_checks = 0;
  int n_pass = 0;
  int n_inst_ok = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level reference: at most one outstanding transaction record.
  bit          m_busy = 1'b0;
  bit          m_is_data = 1'b0;
  bit          m_addr_done = 1'b0;
  bit          m_disc = 1'b0;
  bit          m_iok = 1'b0;
  bit          m_dok = 1'b0;
  bit          m_fin = 1'b0;
  bit          m_ok_now = 1'b0;
  logic        m_wr = 1'b0;
  logic [1:0]  m_size = 2'd0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_wdata = 32'd0;
  logic [31:0] m_irdata = 32'd0;
  logic [31:0] m_drdata = 32'd0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0; m_is_data = 1'b0; m_addr_done = 1'b0; m_disc = 1'b0;
      m_iok = 1'b0; m_dok = 1'b0; m_wr = 1'b0; m_size = 2'd0;
      m_addr = 32'd0; m_wdata = 32'd0; m_irdata = 32'd0; m_drdata = 32'd0;
    end else begin
      m_ok_now = m_iok | m_dok;
      m_iok = 1'b0;
      m_dok = 1'b0;
      m_fin = 1'b0;
      if (!m_busy) begin
        if (!m_ok_now && !flush && (data_req || inst_req)) begin
          m_busy = 1'b1; m_addr_done = 1'b0; m_disc = 1'b0; m_is_data = data_req;
          if (data_req) begin
            m_wr = data_wr; m_size = data_size; m_addr = data_addr; m_wdata = data_wdata;
          end else begin
            m_wr = 1'b0; m_size = 2'd2; m_addr = inst_addr;
          end
        end
      end else begin
        if (flush && !m_is_data) m_disc = 1'b1;
        if (!m_addr_done) begin
          if (bus_addr_ok) begin
            m_addr_done = 1'b1;
            m_fin = bus_data_ok;
          end
        end else begin
          m_fin = bus_data_ok;
        end
        if (m_fin) begin
          m_busy = 1'b0;
          if (m_is_data) begin
            m_dok = 1'b1; m_drdata = bus_rdata;
          end else if (!m_disc) begin
            m_iok = 1'b1; m_irdata = bus_rdata;
          end
        end
      end
    end
  end

  function automatic logic [6:0] exp_stall();
    if (!rst || m_iok || m_dok) return 7'b0000000;
    if ((m_busy && m_is_data) || (!m_busy && data_req && !flush)) return 7'b0111111;
    if (m_busy || (inst_req && !flush)) return 7'b0000011;
    return 7'b0000000;
  endfunction

  // Per-cycle comparison against the model, mid-cycle on the falling edge.
  always @(negedge clk) begin
    chk("m.bus_req", 32'(bus_req), 32'(m_busy && !m_addr_done));
    chk("m.inst_ok", 32'(inst_ok), 32'(m_iok));
    chk("m.data_ok", 32'(data_ok), 32'(m_dok));
    chk("m.stall", 32'(stall), 32'(exp_stall()));
    chk("m.inst_rdata", inst_rdata, m_irdata);
    chk("m.data_rdata", data_rdata, m_drdata);
    if (m_busy && !m_addr_done) begin
      chk("m.bus_wr", 32'(bus_wr), 32'(m_wr));
      chk("m.bus_size", 32'(bus_size), 32'(m_size));
      chk("m.bus_addr", bus_addr, m_addr);
      if (m_is_data) chk("m.bus_wdata", bus_wdata, m_wdata);
    end
    if (inst_ok === 1'b1) n_inst_ok++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    flush = 0; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_size = 0;
    data_addr = 0; data_wdata = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    tick(); tick();
    #1;
    chk("rst bus_req", 32'(bus_req), 32'd0);
    chk("rst bus_size", 32'(bus_size), 32'd0);
    chk("rst bus_addr", bus_addr, 32'd0);
    chk("rst inst_ok", 32'(inst_ok), 32'd0);
    chk("rst data_rdata", data_rdata, 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    tick(); rst = 1'b1;
    tick(); #1 chk("idle stall", 32'(stall), 32'd0);

    // Load with minimum latency.
    tick(); data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h1000_0040;
    #1 chk("ld stall N", 32'(stall), 32'h3F);
    tick(); bus_addr_ok = 1;
    #1 chk("ld bus_req", 32'(bus_req), 32'd1);
    chk("ld bus_addr", bus_addr, 32'h1000_0040);
    chk("ld bus_size", 32'(bus_size), 32'd2);
    chk("ld stall N+1", 32'(stall), 32'h3F);
    tick(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hDEAD_BEEF;
    #1 chk("ld stall N+2", 32'(stall), 32'h3F);
    tick(); bus_data_ok = 0;
    #1 chk("ld data_ok", 32'(data_ok), 32'd1);
    chk("ld data_rdata", data_rdata, 32'hDEAD_BEEF);
    chk("ld stall N+3", 32'(stall), 32'd0);
    tick(); data_req = 0;
    #1 chk("ld ok one cycle", 32'(data_ok), 32'd0);

    // Simultaneous requests: data first, then fetch completing in the address phase.
    tick(); inst_req = 1; inst_addr = 32'h0040_0000; data_req = 1; data_addr = 32'h2000_0010;
    #1 chk("both stall", 32'(stall), 32'h3F);
    tick(); bus_addr_ok = 1;
    #1 chk("both first addr", bus_addr, 32'h2000_0010);
    tick(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h1111_1111;
    tick(); bus_data_ok = 0;
    #1 chk("both data_ok", 32'(data_ok), 32'd1);
    chk("both stall ok", 32'(stall), 32'd0);
    tick(); data_req = 0;
    #1 chk("fetch stall", 32'(stall), 32'h03);
    tick(); bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h2222_2222;
    #1 chk("fetch bus_addr", bus_addr, 32'h0040_0000);
    chk("fetch bus_wr", 32'(bus_wr), 32'd0);
    chk("fetch bus_size", 32'(bus_size), 32'd2);
    tick(); bus_addr_ok = 0; bus_data_ok = 0;
    #1 chk("fetch inst_ok", 32'(inst_ok), 32'd1);
    chk("fetch inst_rdata", inst_rdata, 32'h2222_2222);
    chk("fetch stall ok", 32'(stall), 32'd0);
    tick(); inst_req = 0;
    #1 chk("fetch ok one cycle", 32'(inst_ok), 32'd0);

    // Fetch flushed during its data phase.
    tick(); inst_req = 1; inst_addr = 32'h0040_0004;
    tick(); bus_addr_ok = 1;
    tick(); bus_addr_ok = 0; flush = 1;
    #1 chk("flush stall", 32'(stall), 32'h03);
    tick(); flush = 0; inst_req = 0; bus_data_ok = 1; bus_rdata = 32'h3333_3333;
    #1 chk("drain stall", 32'(stall), 32'h03);
    tick(); bus_data_ok = 0;
    #1 chk("flush no inst_ok", 32'(inst_ok), 32'd0);
    chk("flush stall clear", 32'(stall), 32'd0);
    chk("flush rdata held", inst_rdata, 32'h2222_2222);

    // Store with a slow address handshake.
    tick(); data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h3000_0003; data_wdata = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1 chk("st hold bus_req", 32'(bus_req), 32'd1);
      chk("st hold bus_wr", 32'(bus_wr), 32'd1);
      chk("st hold bus_size", 32'(bus_size), 32'd0);
      chk("st hold bus_addr", bus_addr, 32'h3000_0003);
      chk("st hold bus_wdata", bus_wdata, 32'h1234_5678);
    end
    tick(); bus_addr_ok = 1;
    tick(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hAAAA_AAAA;
    #1 chk("st bus_req low", 32'(bus_req), 32'd0);
    tick(); bus_data_ok = 0;
    #1 chk("st data_ok", 32'(data_ok), 32'd1);
    tick(); data_req = 0; data_wr = 0;

    // Stray bus handshakes in IDLE are ignored.
    tick(); bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h9999_9999;
    tick(); bus_addr_ok = 0; bus_data_ok = 0;
    #1 chk("stray data_ok", 32'(data_ok), 32'd0);
    chk("stray inst_ok", 32'(inst_ok), 32'd0);
    chk("stray data_rdata", data_rdata, 32'hAAAA_AAAA);

    // Reset in the middle of a load's data phase.
    tick(); data_req = 1; data_size = 2; data_addr = 32'h4000_0000;
    tick(); bus_addr_ok = 1;
    tick(); bus_addr_ok = 0;
    #1 chk("mid stall", 32'(stall), 32'h3F);
    rst = 1'b0; data_req = 0;
    #1 chk("arst bus_req", 32'(bus_req), 32'd0);
    chk("arst bus_addr", bus_addr, 32'd0);
    chk("arst data_rdata", data_rdata, 32'd0);
    chk("arst stall", 32'(stall), 32'd0);
    tick(); rst = 1'b1;
    tick(); bus_data_ok = 1; bus_rdata = 32'h5555_5555;
    tick(); bus_data_ok = 0;
    #1 chk("late data_ok", 32'(data_ok), 32'd0);
    chk("late data_rdata", data_rdata, 32'd0);
    tick(); tick();
    chk("inst_ok count", 32'(n_inst_ok), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
